// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: start gating, load-use stall,
// taken-branch flush and back-end freeze for multi-cycle data-memory accesses.
module hazard_ctrl #(
  parameter int unsigned MEM_LAT = 3,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [4:0]       IFID_rs_i,
  input  logic [4:0]       IFID_rt_i,
  input  logic             IFID_uses_rt_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_rt_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  output logic             HD_o,
  output logic             IFID_flush_o,
  output logic             IDEX_bubble_o,
  output logic             pipe_hold_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {IDLE, RUN, MEM_WAIT} state_e;

  // The request cycle itself is the first hold cycle and the RUN->MEM_WAIT
  // transition costs one more, so the counter is preloaded with MEM_LAT-3.
  localparam bit        HAS_HOLD  = (MEM_LAT > 1);
  localparam bit        HAS_WAIT  = (MEM_LAT >= 3);
  localparam logic [7:0] WAIT_INIT = HAS_WAIT ? 8'(MEM_LAT - 3) : 8'd0;

  state_e           state_q, state_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic mh, lu;
  logic hd, flush, bubble, hold;

  assign mh = dmem_req_i && HAS_HOLD;
  assign lu = IDEX_MemRead_i && (IDEX_rt_i != 5'd0) &&
              ((IDEX_rt_i == IFID_rs_i) ||
               (IFID_uses_rt_i && (IDEX_rt_i == IFID_rt_i)));

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    hd      = 1'b0;
    flush   = 1'b0;
    bubble  = 1'b0;
    hold    = 1'b0;
    case (state_q)
      IDLE: begin
        hd     = 1'b1;
        bubble = 1'b1;
        if (start_i) state_d = RUN;
      end
      RUN: begin
        if (mh) begin
          hold = 1'b1;
          hd   = 1'b1;
          if (HAS_WAIT) begin
            state_d = MEM_WAIT;
            wcnt_d  = WAIT_INIT;
          end
        end else if (lu) begin
          // a branch seen alongside a load-use stall is re-evaluated next cycle
          hd     = 1'b1;
          bubble = 1'b1;
        end else if (branch_taken_i) begin
          flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        hold = 1'b1;
        hd   = 1'b1;
        if (wcnt_q == 8'd0) state_d = RUN;
        else                wcnt_d  = wcnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q != IDLE && hd && stall_cnt_q != {CNT_W{1'b1}})
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      wcnt_q      <= 8'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign HD_o          = hd;
  assign IFID_flush_o  = flush;
  assign IDEX_bubble_o = bubble;
  assign pipe_hold_o   = hold;
  assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: five instances with different MEM_LAT /
// CNT_W share the stimulus; each expectation names the instance it targets.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, uses_rt, memrd, br, dmem;
  logic [4:0] rs, rt, idex_rt;

  logic [4:0]  hd_w, fl_w, bu_w, ho_w;
  logic [31:0] cnt_w [5];
  logic [31:0] c0, c1, c2, c3;
  logic [3:0]  c4;

  hazard_ctrl #(.MEM_LAT(3), .CNT_W(32)) u_l3 (.clk_i(clk), .rst_i(rst), .start_i(start),
    .IFID_rs_i(rs), .IFID_rt_i(rt), .IFID_uses_rt_i(uses_rt), .IDEX_MemRead_i(memrd),
    .IDEX_rt_i(idex_rt), .branch_taken_i(br), .dmem_req_i(dmem), .HD_o(hd_w[0]),
    .IFID_flush_o(fl_w[0]), .IDEX_bubble_o(bu_w[0]), .pipe_hold_o(ho_w[0]), .stall_cnt_o(c0));
  hazard_ctrl #(.MEM_LAT(5), .CNT_W(32)) u_l5 (.clk_i(clk), .rst_i(rst), .start_i(start),
    .IFID_rs_i(rs), .IFID_rt_i(rt), .IFID_uses_rt_i(uses_rt), .IDEX_MemRead_i(memrd),
    .IDEX_rt_i(idex_rt), .branch_taken_i(br), .dmem_req_i(dmem), .HD_o(hd_w[1]),
    .IFID_flush_o(fl_w[1]), .IDEX_bubble_o(bu_w[1]), .pipe_hold_o(ho_w[1]), .stall_cnt_o(c1));
  hazard_ctrl #(.MEM_LAT(1), .CNT_W(32)) u_l1 (.clk_i(clk), .rst_i(rst), .start_i(start),
    .IFID_rs_i(rs), .IFID_rt_i(rt), .IFID_uses_rt_i(uses_rt), .IDEX_MemRead_i(memrd),
    .IDEX_rt_i(idex_rt), .branch_taken_i(br), .dmem_req_i(dmem), .HD_o(hd_w[2]),
    .IFID_flush_o(fl_w[2]), .IDEX_bubble_o(bu_w[2]), .pipe_hold_o(ho_w[2]), .stall_cnt_o(c2));
  hazard_ctrl #(.MEM_LAT(4), .CNT_W(32)) u_l4 (.clk_i(clk), .rst_i(rst), .start_i(start),
    .IFID_rs_i(rs), .IFID_rt_i(rt), .IFID_uses_rt_i(uses_rt), .IDEX_MemRead_i(memrd),
    .IDEX_rt_i(idex_rt), .branch_taken_i(br), .dmem_req_i(dmem), .HD_o(hd_w[3]),
    .IFID_flush_o(fl_w[3]), .IDEX_bubble_o(bu_w[3]), .pipe_hold_o(ho_w[3]), .stall_cnt_o(c3));
  hazard_ctrl #(.MEM_LAT(3), .CNT_W(4)) u_c4 (.clk_i(clk), .rst_i(rst), .start_i(start),
    .IFID_rs_i(rs), .IFID_rt_i(rt), .IFID_uses_rt_i(uses_rt), .IDEX_MemRead_i(memrd),
    .IDEX_rt_i(idex_rt), .branch_taken_i(br), .dmem_req_i(dmem), .HD_o(hd_w[4]),
    .IFID_flush_o(fl_w[4]), .IDEX_bubble_o(bu_w[4]), .pipe_hold_o(ho_w[4]), .stall_cnt_o(c4));

  always_comb begin
    cnt_w[0] = c0;
    cnt_w[1] = c1;
    cnt_w[2] = c2;
    cnt_w[3] = c3;
    cnt_w[4] = {28'd0, c4};
  end

  typedef struct {
    int          d;
    logic [3:0]  flags;  // {HD, flush, bubble, hold}
    logic [31:0] cnt;
    string       name;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    exp_t e;
    logic [3:0] f;
    if (q.size() > 0) begin
      e = q.pop_front();
      f = {hd_w[e.d], fl_w[e.d], bu_w[e.d], ho_w[e.d]};
      checks++;
      if (f !== e.flags) begin
        errors++;
        $display("FAIL %s dut%0d hd/flush/bubble/hold got %b want %b", e.name, e.d, f, e.flags);
      end
      checks++;
      if (cnt_w[e.d] !== e.cnt) begin
        errors++;
        $display("FAIL %s dut%0d stall_cnt got %0d want %0d", e.name, e.d, cnt_w[e.d], e.cnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    start = 1'b0; rs = 5'd0; rt = 5'd0; uses_rt = 1'b0;
    memrd = 1'b0; idex_rt = 5'd0; br = 1'b0; dmem = 1'b0;
  endtask

  task automatic ex(input int d, input logic hd, input logic fl, input logic bu,
                    input logic ho, input logic [31:0] c, input string n);
    exp_t e;
    e.d = d; e.flags = {hd, fl, bu, ho}; e.cnt = c; e.name = n;
    q.push_back(e);
  endtask

  task automatic lu_set(input logic [4:0] r);
    memrd = 1'b1; idex_rt = r; rs = r;
  endtask

  // reset one cycle, start, then one quiet RUN cycle
  task automatic reset_start(input int d);
    tick(); quiet(); rst = 1'b0;            ex(d, 1, 0, 1, 0, 0, "rst");
    tick(); rst = 1'b1; start = 1'b1;       ex(d, 1, 0, 1, 0, 0, "start_cycle");
    tick(); quiet();                        ex(d, 0, 0, 0, 0, 0, "run_quiet");
  endtask

  initial begin
    rst = 1'b0;
    quiet();
    // --- MEM_LAT=3: reset, idle, start, load-use, mem hold, branch
    repeat (3) begin tick(); ex(0, 1, 0, 1, 0, 0, "in_reset"); end
    tick(); rst = 1'b1;
    ex(0, 1, 0, 1, 0, 0, "idle");
    repeat (4) begin tick(); ex(0, 1, 0, 1, 0, 0, "idle"); end
    tick(); start = 1'b1;                   ex(0, 1, 0, 1, 0, 0, "start_cycle");
    tick(); start = 1'b0;                   ex(0, 0, 0, 0, 0, 0, "run_quiet");
    tick(); lu_set(5'd8);                   ex(0, 1, 0, 1, 0, 0, "lu_rs");
    tick(); quiet();                        ex(0, 0, 0, 0, 0, 1, "after_lu");
    tick(); lu_set(5'd0);                   ex(0, 0, 0, 0, 0, 1, "lu_r0");
    tick(); quiet(); memrd = 1'b1; idex_rt = 5'd9; rt = 5'd9; rs = 5'd3;
                                            ex(0, 0, 0, 0, 0, 1, "lu_rt_unused");
    tick(); uses_rt = 1'b1;                 ex(0, 1, 0, 1, 0, 1, "lu_rt_used");
    tick(); quiet();                        ex(0, 0, 0, 0, 0, 2, "after_lu_rt");
    tick(); dmem = 1'b1;                    ex(0, 1, 0, 0, 1, 2, "mh3_c1");
    tick();                                 ex(0, 1, 0, 0, 1, 3, "mh3_c2");
    tick(); dmem = 1'b0;                    ex(0, 0, 0, 0, 0, 4, "mh3_done");
    tick(); dmem = 1'b1;                    ex(0, 1, 0, 0, 1, 4, "b2b_a1");
    tick(); dmem = 1'b0;                    ex(0, 1, 0, 0, 1, 5, "b2b_a2");
    tick(); dmem = 1'b1;                    ex(0, 1, 0, 0, 1, 6, "b2b_b1");
    tick(); dmem = 1'b0;                    ex(0, 1, 0, 0, 1, 7, "b2b_b2");
    tick();                                 ex(0, 0, 0, 0, 0, 8, "b2b_done");
    tick(); lu_set(5'd8); br = 1'b1;        ex(0, 1, 0, 1, 0, 8, "lu_beats_br");
    tick(); quiet(); br = 1'b1;             ex(0, 0, 1, 0, 0, 9, "br_flush");
    tick(); quiet();                        ex(0, 0, 0, 0, 0, 9, "after_br");
    // --- MEM_LAT=5: four hold cycles
    reset_start(1);
    tick(); dmem = 1'b1;                    ex(1, 1, 0, 0, 1, 0, "mh5_c1");
    tick(); dmem = 1'b0;                    ex(1, 1, 0, 0, 1, 1, "mh5_c2");
    tick();                                 ex(1, 1, 0, 0, 1, 2, "mh5_c3");
    tick();                                 ex(1, 1, 0, 0, 1, 3, "mh5_c4");
    tick();                                 ex(1, 0, 0, 0, 0, 4, "mh5_done");
    // --- MEM_LAT=1: no hold at all
    reset_start(2);
    tick(); dmem = 1'b1;                    ex(2, 0, 0, 0, 0, 0, "mh1_none");
    tick(); lu_set(5'd5);                   ex(2, 1, 0, 1, 0, 0, "mh1_lu");
    tick(); quiet();                        ex(2, 0, 0, 0, 0, 1, "mh1_after");
    // --- MEM_LAT=4: inputs ignored during wait, then reset mid-hold
    reset_start(3);
    tick(); dmem = 1'b1;                    ex(3, 1, 0, 0, 1, 0, "mh4_c1");
    tick(); dmem = 1'b0; lu_set(5'd7); br = 1'b1;
                                            ex(3, 1, 0, 0, 1, 1, "mw_ignore_c2");
    tick();                                 ex(3, 1, 0, 0, 1, 2, "mw_ignore_c3");
    tick(); quiet();                        ex(3, 0, 0, 0, 0, 3, "mh4_done");
    tick(); dmem = 1'b1;                    ex(3, 1, 0, 0, 1, 3, "mh4_r1");
    tick(); dmem = 1'b0; rst = 1'b0;        ex(3, 1, 0, 1, 0, 0, "rst_mid_wait");
    tick(); rst = 1'b1;                     ex(3, 1, 0, 1, 0, 0, "idle_after_rst");
    // --- CNT_W=4: saturation
    reset_start(4);
    for (int i = 0; i < 20; i++) begin
      tick(); lu_set(5'd8);
      ex(4, 1, 0, 1, 0, (i < 15) ? i : 15, "sat");
    end
    tick(); quiet();                        ex(4, 0, 0, 0, 0, 15, "sat_hold");
    for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage CPU.
- Produces the stall signal consumed by the PC's HD_i, plus IF/ID flush, ID/EX bubble and a back-end freeze for multi-cycle data-memory accesses.
- Holds a start-gating FSM, a memory-wait counter and a stall performance counter.
- Hazard outputs are Mealy: combinational from registered state and current inputs, valid in the same cycle.

Parameters:
- MEM_LAT, 3, data-memory access latency in cycles. Legal range 1..255; 1 means no wait.
- CNT_W, 32, width of stall_cnt_o.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  CPU start. Sticky once seen high.
- IFID_rs_i  input  5  rs of the instruction in ID.
- IFID_rt_i  input  5  rt of the instruction in ID.
- IFID_uses_rt_i  input  1  ID instruction reads rt.
- IDEX_MemRead_i  input  1  the instruction in EX is a load.
- IDEX_rt_i  input  5  load destination register in EX.
- branch_taken_i  input  1  branch resolved taken in ID.
- dmem_req_i  input  1  the instruction in MEM starts a data-memory access.
- HD_o  output  1  stall the PC and hold IF/ID (drives PC HD_i).
- IFID_flush_o  output  1  zero the IF/ID register.
- IDEX_bubble_o  output  1  zero the ID/EX control fields.
- pipe_hold_o  output  1  freeze ID/EX, EX/MEM and MEM/WB.
- stall_cnt_o  output  CNT_W  count of stall cycles.

Behaviour:
- States: IDLE, RUN, MEM_WAIT. Internal 8-bit wait counter wcnt.
- Reset (rst_i=0, async):
  - state=IDLE, wcnt=0, stall_cnt_o=0.
  - Outputs while in reset: HD_o=1, IDEX_bubble_o=1, IFID_flush_o=0, pipe_hold_o=0.
  - Reset asserted mid-MEM_WAIT aborts the wait immediately.
- IDLE:
  - Outputs: HD_o=1, IDEX_bubble_o=1, IFID_flush_o=0, pipe_hold_o=0.
  - Goes to RUN on the clock edge where start_i=1; outputs in that cycle keep IDLE values.
  - Deasserting start_i later has no effect.
  - No stall counting in IDLE.
- RUN, evaluated in this priority:
  1. Memory hold (mh): mh = dmem_req_i && MEM_LAT>1.
     - If mh: pipe_hold_o=1, HD_o=1, IDEX_bubble_o=0, IFID_flush_o=0.
     - If MEM_LAT>=3: wcnt<=MEM_LAT-3, next state MEM_WAIT. Otherwise stay in RUN.
     - Total hold = MEM_LAT-1 consecutive cycles, counting the request cycle.
  2. Load-use (lu): lu = IDEX_MemRead_i && IDEX_rt_i!=0 && (IDEX_rt_i==IFID_rs_i || (IFID_uses_rt_i && IDEX_rt_i==IFID_rt_i)).
     - If lu: HD_o=1, IDEX_bubble_o=1, IFID_flush_o=0, for exactly one cycle; stays in RUN.
     - lu with branch_taken_i in the same cycle: the stall wins, no flush; the branch is re-evaluated next cycle.
  3. Taken branch: if branch_taken_i, IFID_flush_o=1 and HD_o=0.
  4. Otherwise all hazard outputs are 0.
- MEM_WAIT:
  - pipe_hold_o=1, HD_o=1, IDEX_bubble_o=0, IFID_flush_o=0.
  - dmem_req_i, lu and branch_taken_i are ignored (the same instruction is still held in MEM).
  - If wcnt==0, next state RUN; else wcnt<=wcnt-1.
- Back-to-back accesses: a dmem_req_i seen in RUN on the cycle right after MEM_WAIT exits is a new access and starts a new hold.
- stall_cnt_o:
  - Increments on every clock edge where state!=IDLE and HD_o=1.
  - Saturates at 2^CNT_W-1; no wrap-around.
- MEM_LAT=1: mh is never asserted and MEM_WAIT is unreachable.

Test Plan:
- Reset low 3 cycles, start_i=0 for 5 cycles -> HD_o=1, IDEX_bubble_o=1 throughout, stall_cnt_o=0. Then start_i=1 -> RUN from the next cycle, HD_o=0 with quiet inputs.
- RUN, IDEX_MemRead_i=1, IDEX_rt_i=8, IFID_rs_i=8 -> HD_o=1 and IDEX_bubble_o=1 for 1 cycle, stall_cnt_o +1. Repeat with IDEX_rt_i=0 -> no stall. Repeat with rt match and IFID_uses_rt_i=0 -> no stall.
- MEM_LAT=3, dmem_req_i pulse held for 2 cycles -> pipe_hold_o=HD_o=1 for exactly 2 cycles, then 0, stall_cnt_o +2. MEM_LAT=5 -> 4 hold cycles. MEM_LAT=1 -> 0 hold cycles.
- Same cycle: load-use match and branch_taken_i=1 -> HD_o=1, IFID_flush_o=0. Next cycle, branch_taken_i=1 without the hazard -> IFID_flush_o=1, HD_o=0.
- During MEM_WAIT (MEM_LAT=4), drive load-use match and branch_taken_i=1 -> IDEX_bubble_o=0, IFID_flush_o=0, hold lasts 3 cycles total. Assert rst_i=0 in hold cycle 2 -> immediate IDLE outputs, stall_cnt_o=0.
- CNT_W=4: force 20 stall cycles -> stall_cnt_o saturates at 15.
